// File: rtl/sync_decoder_pkg.sv
// Shared types for the sync decoder: lock FSM states and sync polarity encoding.
// Imported by the decoder top and by its edge-detector sub-module.
package sync_decoder_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_t;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/sync_decoder_sync_edge.sv
// Three-flop synchroniser for a raw sync input, normalised to active-high,
// followed by a rising-edge detector on the two oldest stages.
module sync_edge
    import sync_decoder_pkg::*;
#(
    parameter bit POL = POL_ACTIVE_HIGH
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make s1..s3 a true shift pipeline.
            s1 <= sync_in ^ ~POL;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/sync_decoder.sv
// Recovers pixel/line timing from external HSYNC/VSYNC: measures line length,
// locks onto a stable line rate and emits registered X/Y, ACTIVE and frame pulse.
module sync_decoder
    import sync_decoder_pkg::*;
#(
    parameter int CW         = 12,
    parameter int H_BACK     = 40,
    parameter int H_ACTIVE   = 640,
    parameter int V_BACK     = 20,
    parameter int V_ACTIVE   = 480,
    parameter int LOCK_LINES = 4,
    parameter int TOL        = 2,
    parameter int TIMEOUT    = 4000,
    parameter bit SYNC_POL   = POL_ACTIVE_HIGH
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          HSYNC,
    input  logic          VSYNC,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          ACTIVE,
    output logic          LOCKED,
    output logic          FRAME_START,
    output logic [CW-1:0] LINE_LEN
);

    localparam int CW1 = CW + 1;
    localparam int MW  = $clog2(LOCK_LINES + 1);

    localparam logic [CW:0]   TIMEOUT_W = CW1'(TIMEOUT);
    localparam logic [CW:0]   TOL_W     = CW1'(TOL);
    localparam logic [CW:0]   H_LO      = CW1'(H_BACK);
    localparam logic [CW:0]   H_HI      = CW1'(H_BACK + H_ACTIVE);
    localparam logic [CW:0]   V_LO      = CW1'(V_BACK);
    localparam logic [CW:0]   V_HI      = CW1'(V_BACK + V_ACTIVE);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_LINES - 1);

    logic          hs_rise;
    logic          vs_rise;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW-1:0] prev_len;
    logic          prev_valid;
    logic [MW-1:0] match_cnt;
    logic          miss_cnt;
    logic          vs_d;
    lock_state_t   state;

    sync_edge #(.POL(SYNC_POL)) u_hs_edge (.clk(CLK), .rst(RST), .sync_in(HSYNC), .rise(hs_rise));
    sync_edge #(.POL(SYNC_POL)) u_vs_edge (.clk(CLK), .rst(RST), .sync_in(VSYNC), .rise(vs_rise));

    // All length/window arithmetic is one bit wider than the counters so nothing wraps.
    logic [CW:0] h_cnt_w;
    logic [CW:0] v_cnt_w;
    logic [CW:0] line_len_w;
    logic [CW:0] prev_w;
    logic [CW:0] len_diff;
    logic        len_match;
    logic        timeout;
    logic        active_next;

    assign h_cnt_w     = {1'b0, h_cnt};
    assign v_cnt_w     = {1'b0, v_cnt};
    assign line_len_w  = h_cnt_w + 1'b1;
    assign prev_w      = {1'b0, prev_len};
    assign len_diff    = (line_len_w > prev_w) ? line_len_w - prev_w : prev_w - line_len_w;
    assign len_match   = (len_diff <= TOL_W);
    assign timeout     = !hs_rise && (h_cnt_w >= TIMEOUT_W);
    assign active_next = (state == ST_LOCKED)
                      && (h_cnt_w >= H_LO) && (h_cnt_w < H_HI)
                      && (v_cnt_w >= V_LO) && (v_cnt_w < V_HI);

    always_ff @(posedge CLK) begin
        if (RST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (hs_rise)
                h_cnt <= '0;
            else if (h_cnt_w < TIMEOUT_W)
                h_cnt <= h_cnt + 1'b1;

            if (vs_rise)
                v_cnt <= '0;
            else if (hs_rise && (v_cnt != '1))
                v_cnt <= v_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_SEARCH;
            match_cnt  <= '0;
            miss_cnt   <= 1'b0;
            prev_len   <= '0;
            prev_valid <= 1'b0;
            LINE_LEN   <= '0;
        end else if (hs_rise) begin
            case (state)
                ST_SEARCH: begin
                    // The first edge only opens a line; there is no length to trust yet.
                    state      <= ST_TRACK;
                    match_cnt  <= '0;
                    miss_cnt   <= 1'b0;
                    prev_valid <= 1'b0;
                end
                ST_TRACK: begin
                    LINE_LEN   <= line_len_w[CW-1:0];
                    prev_len   <= line_len_w[CW-1:0];
                    prev_valid <= 1'b1;
                    if (prev_valid && len_match) begin
                        if (match_cnt == LOCK_LAST) begin
                            state     <= ST_LOCKED;
                            match_cnt <= '0;
                            miss_cnt  <= 1'b0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end else begin
                        match_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    LINE_LEN <= line_len_w[CW-1:0];
                    if (len_match) begin
                        miss_cnt <= 1'b0;
                        prev_len <= line_len_w[CW-1:0];
                    end else if (miss_cnt) begin
                        state <= ST_SEARCH;
                    end else begin
                        miss_cnt <= 1'b1;
                    end
                end
                default: state <= ST_SEARCH;
            endcase
        end else if (timeout) begin
            state <= ST_SEARCH;
        end
    end

    // vs_d delays the VSYNC edge so FRAME_START lines up with the first outputs of the new frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            X           <= '0;
            Y           <= '0;
            ACTIVE      <= 1'b0;
            LOCKED      <= 1'b0;
            FRAME_START <= 1'b0;
            vs_d        <= 1'b0;
        end else begin
            vs_d        <= vs_rise;
            ACTIVE      <= active_next;
            LOCKED      <= (state == ST_LOCKED);
            FRAME_START <= vs_d && (state == ST_LOCKED);
            X           <= active_next ? h_cnt - CW'(H_BACK) : '0;
            Y           <= active_next ? v_cnt - CW'(V_BACK) : '0;
        end
    end

endmodule
